// File: rtl/aes_axis_request_master.sv
// Host-side stream master for the AES accelerator: serialises one block+key request
// onto m00, then collects the result packet from s00 into a single parallel response.
module aes_axis_request_master #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int BLK_WORDS          = 4,
    parameter int KEY_WORDS          = 4,
    parameter int RESP_WORDS         = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [0:BLK_WORDS*C_AXIS_TDATA_WIDTH-1]  req_plaintext,
    input  logic [0:KEY_WORDS*C_AXIS_TDATA_WIDTH-1]  req_key,
    output logic                                 m00_axis_tvalid,
    output logic [C_AXIS_TDATA_WIDTH-1:0]        m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]      m00_axis_tstrb,
    output logic                                 m00_axis_tlast,
    input  logic                                 m00_axis_tready,
    input  logic                                 s00_axis_tvalid,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]        s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]      s00_axis_tstrb,
    input  logic                                 s00_axis_tlast,
    output logic                                 s00_axis_tready,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic [0:RESP_WORDS*C_AXIS_TDATA_WIDTH-1] resp_data,
    output logic                                 resp_err
);
    localparam int W        = C_AXIS_TDATA_WIDTH;
    localparam int TX_WORDS = BLK_WORDS + KEY_WORDS;
    localparam int TX_IW    = (TX_WORDS > 1) ? $clog2(TX_WORDS) : 1;
    localparam int RX_IW    = (RESP_WORDS > 1) ? $clog2(RESP_WORDS) : 1;
    localparam logic [TX_IW-1:0] TX_LAST = TX_IW'(TX_WORDS - 1);
    localparam logic [RX_IW-1:0] RX_LAST = RX_IW'(RESP_WORDS - 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t                   state_reg, state_next;
    logic [TX_IW-1:0]         tx_idx_reg;
    logic [RX_IW-1:0]         rx_idx_reg;
    logic [0:TX_WORDS*W-1]    tx_buf_reg;
    logic [W-1:0]             resp_word_reg [RESP_WORDS];
    logic                     resp_err_reg;
    logic [W-1:0]             tx_words [TX_WORDS];

    logic accept, tx_fire, rx_fire, tx_final, rx_final;
    logic unused_tstrb;

    assign unused_tstrb = ^s00_axis_tstrb;
    assign accept   = req_valid && req_ready;
    assign tx_fire  = m00_axis_tvalid && m00_axis_tready;
    assign rx_fire  = s00_axis_tvalid && s00_axis_tready;
    assign tx_final = tx_fire && (tx_idx_reg == TX_LAST);
    // The result packet ends on TLAST or when the response buffer is full, whichever comes first.
    assign rx_final = rx_fire && (s00_axis_tlast || (rx_idx_reg == RX_LAST));

    generate
        for (genvar gi = 0; gi < TX_WORDS; gi++) begin : g_tx_words
            assign tx_words[gi] = tx_buf_reg[gi*W +: W];
        end
        for (genvar gi = 0; gi < RESP_WORDS; gi++) begin : g_resp_words
            assign resp_data[gi*W +: W] = resp_word_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept)     state_next = SEND;
            SEND: if (tx_final)   state_next = RECV;
            RECV: if (rx_final)   state_next = DONE;
            DONE: if (resp_ready) state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (state_reg == IDLE);
        m00_axis_tvalid = (state_reg == SEND);
        m00_axis_tdata  = (state_reg == SEND) ? tx_words[tx_idx_reg] : '0;
        m00_axis_tlast  = (state_reg == SEND) && (tx_idx_reg == TX_LAST);
        m00_axis_tstrb  = '1;
        s00_axis_tready = (state_reg == RECV);
        resp_valid      = (state_reg == DONE);
        resp_err        = resp_err_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_idx_reg   <= '0;
            rx_idx_reg   <= '0;
            tx_buf_reg   <= '0;
            resp_err_reg <= 1'b0;
            for (int i = 0; i < RESP_WORDS; i++) begin
                resp_word_reg[i] <= '0;
            end
        end else begin
            if (accept) begin
                tx_idx_reg   <= '0;
                rx_idx_reg   <= '0;
                tx_buf_reg   <= {req_plaintext, req_key};
                resp_err_reg <= 1'b0;
                for (int i = 0; i < RESP_WORDS; i++) begin
                    resp_word_reg[i] <= '0;
                end
            end
            if (tx_fire && !tx_final) begin
                tx_idx_reg <= tx_idx_reg + 1'b1;
            end
            if (rx_fire) begin
                resp_word_reg[rx_idx_reg] <= s00_axis_tdata;
                // Short packet (early TLAST) or long packet (no TLAST on the final slot).
                if (s00_axis_tlast != (rx_idx_reg == RX_LAST)) begin
                    resp_err_reg <= 1'b1;
                end
                if (!rx_final) begin
                    rx_idx_reg <= rx_idx_reg + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_axis_request_master.sv
// Directed bench for aes_axis_request_master: table of request/reply scenarios plus a
// mid-transfer reset sequence.
module tb_aes_axis_request_master;
    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic [0:127]   req_plaintext;
    logic [0:127]   req_key;
    logic           m00_axis_tvalid;
    logic [31:0]    m00_axis_tdata;
    logic [3:0]     m00_axis_tstrb;
    logic           m00_axis_tlast;
    logic           m00_axis_tready;
    logic           s00_axis_tvalid;
    logic [31:0]    s00_axis_tdata;
    logic [3:0]     s00_axis_tstrb;
    logic           s00_axis_tlast;
    logic           s00_axis_tready;
    logic           resp_valid;
    logic           resp_ready;
    logic [0:127]   resp_data;
    logic           resp_err;

    always #5 clk = ~clk;

    aes_axis_request_master dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_plaintext   (req_plaintext),
        .req_key         (req_key),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tstrb  (m00_axis_tstrb),
        .m00_axis_tlast  (m00_axis_tlast),
        .m00_axis_tready (m00_axis_tready),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tstrb  (s00_axis_tstrb),
        .s00_axis_tlast  (s00_axis_tlast),
        .s00_axis_tready (s00_axis_tready),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_err        (resp_err)
    );

    typedef struct packed {
        logic [0:127] pt;
        logic [0:127] key;
        logic [0:159] reply;      // up to five reply words, word 0 first
        int           reply_len;
        int           last_pos;   // beat index carrying TLAST (out of range = none)
        int           exp_taken;  // beats the DUT should accept
        logic [0:127] exp_resp;
        logic         exp_err;
        logic         bp;         // random m00 backpressure
        int           hold;       // cycles resp_ready is held low
    } vec_t;

    vec_t vecs [4];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready",  req_ready, 1);
        chk("rst_tvalid",     m00_axis_tvalid, 0);
        chk("rst_tlast",      m00_axis_tlast, 0);
        chk("rst_tdata",      m00_axis_tdata, 0);
        chk("rst_tstrb",      m00_axis_tstrb, 4'hf);
        chk("rst_s00_tready", s00_axis_tready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err",   resp_err, 0);
        chk("rst_resp_data",  resp_data, 0);
    endtask

    task automatic run_txn(input vec_t v);
        logic [0:127] pt;
        logic [0:127] key;
        logic [0:159] rep;
        logic [31:0]  exp_w;
        int k;
        int cyc;
        pt  = v.pt;
        key = v.key;
        rep = v.reply;
        @(negedge clk);
        req_plaintext = pt;
        req_key       = key;
        req_valid     = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        @(negedge clk);
        // A second request held during SEND must be ignored.
        req_plaintext = ~pt;
        req_key       = ~key;
        chk("req_ready_busy", req_ready, 0);
        chk("s00_tready_send", s00_axis_tready, 0);
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 200) begin
            m00_axis_tready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m00_axis_tvalid) begin
                exp_w = (k < 4) ? pt[k*32 +: 32] : key[(k-4)*32 +: 32];
                chk("tx_data", m00_axis_tdata, exp_w);
                chk("tx_last", m00_axis_tlast, (k == 7));
                if (m00_axis_tready) k++;
            end else begin
                chk("tx_valid", m00_axis_tvalid, 1);
            end
            @(negedge clk);
            cyc++;
        end
        chk("tx_count", k, 8);
        m00_axis_tready = 1'b0;
        req_valid = 1'b0;
        chk("tx_valid_after", m00_axis_tvalid, 0);
        chk("s00_tready_recv", s00_axis_tready, 1);
        for (int j = 0; j < v.reply_len; j++) begin
            s00_axis_tvalid = 1'b1;
            s00_axis_tdata  = rep[j*32 +: 32];
            s00_axis_tlast  = (j == v.last_pos);
            chk("rx_tready", s00_axis_tready, (j < v.exp_taken));
            if (!s00_axis_tready) break;
            @(negedge clk);
        end
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        chk("resp_valid", resp_valid, 1);
        chk("resp_data", resp_data, v.exp_resp);
        chk("resp_err", resp_err, v.exp_err);
        chk("req_ready_done", req_ready, 0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, v.exp_resp);
            chk("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_valid_after", resp_valid, 0);
        chk("req_ready_after", req_ready, 1);
        $display("txn pt=%h reply_len=%0d resp=%h err=%0d", pt, v.reply_len, resp_data, resp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:127] pt_b;
        logic [0:127] key_b;
        vecs[0] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
                    reply: 160'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a_00000000, reply_len: 4, last_pos: 3,
                    exp_taken: 4, exp_resp: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, exp_err: 1'b0, bp: 1'b0, hold: 10};
        vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
                    reply: 160'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a_00000000, reply_len: 4, last_pos: 3,
                    exp_taken: 4, exp_resp: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, exp_err: 1'b0, bp: 1'b1, hold: 1};
        vecs[2] = '{pt: 128'h0123456789abcdeffedcba9876543210, key: 128'hdeadbeefcafebabe0badf00d12345678,
                    reply: 160'haaaaaaaa_bbbbbbbb_00000000_00000000_00000000, reply_len: 2, last_pos: 1,
                    exp_taken: 2, exp_resp: 128'haaaaaaaabbbbbbbb0000000000000000, exp_err: 1'b1, bp: 1'b0, hold: 2};
        vecs[3] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'hdeadbeefcafebabe0badf00d12345678,
                    reply: 160'h11111111_22222222_33333333_44444444_55555555, reply_len: 5, last_pos: 9,
                    exp_taken: 4, exp_resp: 128'h11111111222222223333333344444444, exp_err: 1'b1, bp: 1'b1, hold: 1};

        reset = 1'b1;
        req_valid = 1'b0;
        req_plaintext = '0;
        req_key = '0;
        m00_axis_tready = 1'b0;
        s00_axis_tvalid = 1'b0;
        s00_axis_tdata = '0;
        s00_axis_tstrb = '0;
        s00_axis_tlast = 1'b0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i]);
        end

        // Reset while the third word is on the bus: everything returns to idle.
        pt_b  = vecs[2].pt;
        key_b = vecs[2].key;
        @(negedge clk);
        req_plaintext = pt_b;
        req_key = key_b;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        m00_axis_tready = 1'b1;
        chk("rst_seq_w0", m00_axis_tdata, pt_b[0:31]);
        @(negedge clk);
        chk("rst_seq_w1", m00_axis_tdata, pt_b[32:63]);
        @(negedge clk);
        chk("rst_seq_w2", m00_axis_tdata, pt_b[64:95]);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        m00_axis_tready = 1'b0;
        $display("reset mid-transfer checked");
        run_txn(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
